mcpu_alu_mc: RTL

MCPU_ALU_MC -- requirements
Module: mcpu_alu_mc

---
 rtl/mcpu_alu_mc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_alu_mc.sv
// rtl/mcpu_alu_mc.sv - multi-cycle ALU with single-cycle ops, iterative shifts and shift-add multiply
//
// Purpose: accepts an ALU op word plus operands when start is seen in IDLE or
// DONE. Mode 00 ops finish on the accept edge. Shifts move one bit per RUN
// cycle. Multiply takes one shift-add step per RUN cycle. Results are
// registered on the edge that enters DONE and hold until the next completion.
//
// Ports:
//    clk      in   single clock, rising edge
//    reset_n  in   asynchronous active-low reset
//    start    in   request to accept op/operands (ignored while RUN)
//    abort    in   cancel a running op (only acts in RUN)
//    mode     in   00 single-cycle, 01 SHL-by-n, 10 SHR-by-n, 11 MUL
//    op       in   [2:0] op/test select, [3] INV, [4] CIN, [6:5] BOP, [OP_WIDTH-1:7] immediate
//    a,b,x,y  in   operands
//    sense    in   external test flag
//    busy     out  op in progress (RUN)
//    done     out  one-cycle completion pulse (DONE)
//    d_out    out  registered result
//    f_out    out  registered test flag
//    c_out    out  registered carry / shift-out / multiply overflow
module mcpu_alu_mc #(
   parameter int DATA_WIDTH  = 32,
   parameter int OP_WIDTH    = 42,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            mode,
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [DATA_WIDTH-1:0] y,
   input  logic                  sense,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] d_out,
   output logic                  f_out,
   output logic                  c_out
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state, state_nx;
   logic                    accept;
   logic                    go_direct;
   logic [DATA_WIDTH-1:0]   b_sel, b_pre;
   logic [SHAMT_WIDTH-1:0]  n;
   logic                    test_flag;
   logic [DATA_WIDTH:0]     add_full;
   logic [DATA_WIDTH-1:0]   alu_res;
   logic                    alu_c;

   // iterative work registers
   logic [1:0]              run_mode;
   logic [CNT_W-1:0]        cnt;
   logic                    f_lat;
   logic [DATA_WIDTH-1:0]   work;
   logic [DATA_WIDTH-1:0]   shift_nx;
   logic                    shift_out;
   logic [2*DATA_WIDTH-1:0] acc, acc_nx, mcand;
   logic [DATA_WIDTH-1:0]   mplier;
   logic                    last_step;

   assign accept    = start && (state != RUN);
   assign n         = b_pre[SHAMT_WIDTH-1:0];
   // mode 00 and zero-length shifts complete on the accept edge itself
   assign go_direct = (mode == 2'b00) || ((mode != 2'b11) && (n == '0));
   assign last_step = (cnt == CNT_W'(1));

   always_comb begin
      b_sel = b;
      case (op[6:5])
         2'b00:   b_sel = b;
         2'b01:   b_sel = DATA_WIDTH'(op[OP_WIDTH-1:7]);
         2'b10:   b_sel = b >> 1;
         default: b_sel = b << 1;
      endcase
      b_pre = op[3] ? ~b_sel : b_sel;
   end

   // tests use the raw b operand, not b_pre
   always_comb begin
      test_flag = 1'b0;
      case (op[2:0])
         3'd0:    test_flag = (a == '0);
         3'd1:    test_flag = (b == '0);
         3'd2:    test_flag = (a > b);
         3'd3:    test_flag = (a == b);
         3'd4:    test_flag = (a < b);
         3'd5:    test_flag = b[0];
         3'd6:    test_flag = b[DATA_WIDTH-1];
         default: test_flag = sense;
      endcase
      test_flag = test_flag ^ op[3];
   end

   always_comb begin
      add_full = {1'b0, a} + {1'b0, b_pre} + {{DATA_WIDTH{1'b0}}, op[4]};
      alu_c    = 1'b0;
      case (op[2:0])
         3'd0: begin
            alu_res = add_full[DATA_WIDTH-1:0];
            alu_c   = add_full[DATA_WIDTH];
         end
         3'd1:    alu_res = a & b_pre;
         3'd2:    alu_res = a | b_pre;
         3'd3:    alu_res = a ^ b_pre;
         3'd4:    alu_res = a;
         3'd5:    alu_res = b_pre;
         3'd6:    alu_res = x;
         default: alu_res = y;
      endcase
   end

   always_comb begin
      shift_nx  = (run_mode == 2'b01) ? (work << 1) : (work >> 1);
      shift_out = (run_mode == 2'b01) ? work[DATA_WIDTH-1] : work[0];
      acc_nx    = mplier[0] ? (acc + mcand) : acc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         RUN: begin
            busy = 1'b1;
            if (abort)          state_nx = IDLE;
            else if (last_step) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (accept) state_nx = go_direct ? DONE : RUN;
            else        state_nx = IDLE;
         end
         default: begin
            if (accept) state_nx = go_direct ? DONE : RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_out    <= '0;
         f_out    <= 1'b0;
         c_out    <= 1'b0;
         f_lat    <= 1'b0;
         run_mode <= 2'b00;
         cnt      <= '0;
         work     <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
      end else if (accept) begin
         f_lat    <= test_flag;
         run_mode <= mode;
         if (go_direct) begin
            d_out <= (mode == 2'b00) ? alu_res : a;
            c_out <= (mode == 2'b00) ? alu_c : 1'b0;
            f_out <= test_flag;
         end else if (mode == 2'b11) begin
            acc    <= '0;
            mcand  <= {{DATA_WIDTH{1'b0}}, a};
            mplier <= b_pre;
            cnt    <= CNT_W'(DATA_WIDTH);
         end else begin
            work <= a;
            cnt  <= CNT_W'(n);
         end
      end else if (state == RUN && !abort) begin
         cnt <= cnt - CNT_W'(1);
         if (run_mode == 2'b11) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end else begin
            work <= shift_nx;
         end
         if (last_step) begin
            f_out <= f_lat;
            if (run_mode == 2'b11) begin
               d_out <= acc_nx[DATA_WIDTH-1:0];
               c_out <= |acc_nx[2*DATA_WIDTH-1:DATA_WIDTH];
            end else begin
               d_out <= shift_nx;
               c_out <= shift_out;
            end
         end
      end
   end

endmodule
